// File: rtl/hall_pkg.sv
// Shared definitions for the hall position decoder.
// Holds the hall code constants, the empty-sector marker, the tracker
// state encoding and the hall code to sector lookup.
package hall_pkg;

    localparam logic [2:0] SECTOR_NONE = 3'd7;

    localparam logic [2:0] ILLEGAL_000 = 3'b000;
    localparam logic [2:0] ILLEGAL_111 = 3'b111;

    // {hall1,hall2,hall3} code seen in each sector
    localparam logic [2:0] CODE_S0 = 3'b101;
    localparam logic [2:0] CODE_S1 = 3'b100;
    localparam logic [2:0] CODE_S2 = 3'b110;
    localparam logic [2:0] CODE_S3 = 3'b010;
    localparam logic [2:0] CODE_S4 = 3'b011;
    localparam logic [2:0] CODE_S5 = 3'b001;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } hall_state_t;

    function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
        logic [2:0] sec;
        case (code)
            CODE_S0: sec = 3'd0;
            CODE_S1: sec = 3'd1;
            CODE_S2: sec = 3'd2;
            CODE_S3: sec = 3'd3;
            CODE_S4: sec = 3'd4;
            CODE_S5: sec = 3'd5;
            default: sec = SECTOR_NONE;
        endcase
        return sec;
    endfunction

endpackage

// File: rtl/hall_debounce.sv
// Hall input conditioner: 2-FF synchroniser on the three hall lines followed
// by a stability timer. A code is accepted once it has been sampled
// DEBOUNCE_CYCLES consecutive times and differs from the last accepted code,
// so a glitch that returns to the old code produces no accept at all.
// Ports:
//   CLK, reset_n   clock, async active-low reset
//   hall_raw[2:0]  {hall1,hall2,hall3}, asynchronous to CLK
//   code[2:0]      last accepted code
//   accept         1-cycle pulse when code takes a new value
module hall_debounce
    import hall_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic [2:0] hall_raw,
    output logic [2:0] code,
    output logic       accept
);

    localparam logic [15:0] STABLE_LOAD = 16'(DEBOUNCE_CYCLES - 1);

    logic [2:0]  sync1, sync2, cand;
    logic [15:0] stable_cnt, stable_cnt_nxt;
    logic        changed, hit;

    assign changed = (sync2 != cand);

    // Down-counter: reaching zero means DEBOUNCE_CYCLES equal samples seen.
    always_comb begin
        stable_cnt_nxt = stable_cnt;
        hit            = 1'b0;
        if (changed) begin
            stable_cnt_nxt = STABLE_LOAD;
            hit            = (DEBOUNCE_CYCLES == 1);
        end else if (stable_cnt != 16'd0) begin
            stable_cnt_nxt = stable_cnt - 16'd1;
            hit            = (stable_cnt == 16'd1);
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= ILLEGAL_000;
            sync2      <= ILLEGAL_000;
            cand       <= ILLEGAL_000;
            stable_cnt <= 16'd0;
            code       <= ILLEGAL_000;
            accept     <= 1'b0;
        end else begin
            sync1      <= hall_raw;
            sync2      <= sync1;
            cand       <= sync2;
            stable_cnt <= stable_cnt_nxt;
            accept     <= hit && (sync2 != code);
            if (hit) begin
                code <= sync2;
            end
        end
    end

endmodule

// File: rtl/hall_position_decoder.sv
// Hall position decoder: debounced hall code -> sector 0..5, signed step
// count for the commutation controller, direction, step strobe and sticky
// error reporting for illegal codes and skipped sectors.
// Optional windowed velocity estimate when HALL_VELOCITY_EN is defined;
// otherwise velocity and vel_valid are tied low.
// Ports:
//   CLK, reset_n          clock, async active-low reset
//   hall1..hall3          raw hall lines
//   zero_pos, clear_error synchronous pulses
//   position, sector, direction, step_strobe, hall_error, error_count
//   velocity, vel_valid   windowed step rate
//
// state | meaning
// INIT  | no trusted sector; waiting for first legal accepted code
// TRACK | sector valid; accepted codes counted as steps or flagged
module hall_position_decoder
    import hall_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int VEL_WINDOW      = 100000,
    parameter int ERR_CNT_W       = 8
) (
    input  logic                 CLK,
    input  logic                 reset_n,
    input  logic                 hall1,
    input  logic                 hall2,
    input  logic                 hall3,
    input  logic                 zero_pos,
    input  logic                 clear_error,
    output logic signed [31:0]   position,
    output logic [2:0]           sector,
    output logic                 direction,
    output logic                 step_strobe,
    output logic                 hall_error,
    output logic [ERR_CNT_W-1:0] error_count,
    output logic signed [15:0]   velocity,
    output logic                 vel_valid
);

    localparam logic signed [31:0] POS_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] POS_MIN = 32'sh8000_0000;

    logic [2:0]  acc_code, new_sector, sector_d, sec_up, sec_dn;
    logic        accept, legal, sector_ld, step_up, step_dn, err_evt;
    hall_state_t state, state_nxt;

    hall_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .hall_raw ({hall1, hall2, hall3}),
        .code     (acc_code),
        .accept   (accept)
    );

    assign new_sector = hall_to_sector(acc_code);
    assign legal      = (new_sector != SECTOR_NONE);
    assign sec_up     = (sector == 3'd5) ? 3'd0 : sector + 3'd1;
    assign sec_dn     = (sector == 3'd0) ? 3'd5 : sector - 3'd1;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) state <= INIT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (accept && legal)  state_nxt = TRACK;
            TRACK:   if (accept && !legal) state_nxt = INIT;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        sector_ld = 1'b0;
        sector_d  = sector;
        step_up   = 1'b0;
        step_dn   = 1'b0;
        err_evt   = 1'b0;
        if (accept) begin
            case (state)
                INIT: begin
                    if (legal) begin
                        sector_ld = 1'b1;
                        sector_d  = new_sector;
                    end
                end
                TRACK: begin
                    sector_ld = 1'b1;
                    sector_d  = new_sector;
                    if (!legal)                    err_evt = 1'b1;
                    else if (new_sector == sec_up) step_up = 1'b1;
                    else if (new_sector == sec_dn) step_dn = 1'b1;
                    else if (new_sector != sector) err_evt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // zero_pos has priority: the coincident step is dropped entirely,
    // but the sector still follows the hall code.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            sector      <= SECTOR_NONE;
            position    <= 32'sd0;
            direction   <= 1'b1;
            step_strobe <= 1'b0;
        end else begin
            if (sector_ld) sector <= sector_d;
            step_strobe <= 1'b0;
            if (zero_pos) begin
                position <= 32'sd0;
            end else if (step_up || step_dn) begin
                step_strobe <= 1'b1;
                direction   <= step_up;
                if (step_up && position != POS_MAX)      position <= position + 32'sd1;
                else if (step_dn && position != POS_MIN) position <= position - 32'sd1;
            end
        end
    end

    // An error in the same cycle as clear_error leaves a fresh count of one.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            hall_error  <= 1'b0;
            error_count <= '0;
        end else if (err_evt) begin
            hall_error <= 1'b1;
            if (clear_error)             error_count <= ERR_CNT_W'(1);
            else if (error_count != '1)  error_count <= error_count + 1'b1;
        end else if (clear_error) begin
            hall_error  <= 1'b0;
            error_count <= '0;
        end
    end

`ifdef HALL_VELOCITY_EN
    localparam int              WIN_W    = $clog2(VEL_WINDOW);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(VEL_WINDOW - 1);

    logic [WIN_W-1:0]   win_cnt;
    logic signed [15:0] vel_acc;
    logic               cnt_up, cnt_dn;

    assign cnt_up = step_up & ~zero_pos;
    assign cnt_dn = step_dn & ~zero_pos;

    // A step landing on the terminal cycle seeds the next window.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt   <= WIN_LOAD;
            vel_acc   <= 16'sd0;
            velocity  <= 16'sd0;
            vel_valid <= 1'b0;
        end else if (win_cnt == '0) begin
            win_cnt   <= WIN_LOAD;
            velocity  <= vel_acc;
            vel_valid <= 1'b1;
            vel_acc   <= cnt_up ? 16'sd1 : (cnt_dn ? -16'sd1 : 16'sd0);
        end else begin
            win_cnt   <= win_cnt - 1'b1;
            vel_valid <= 1'b0;
            if (cnt_up && vel_acc != 16'sh7FFF)      vel_acc <= vel_acc + 16'sd1;
            else if (cnt_dn && vel_acc != 16'sh8000) vel_acc <= vel_acc - 16'sd1;
        end
    end
`else
    localparam int unused_vel_window = VEL_WINDOW;
    assign velocity  = 16'sd0;
    assign vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_hall_position_decoder.sv
module tb_hall_position_decoder;

    localparam int DEB = 16;
    localparam int LAT = DEB + 3;
    localparam int WIN = 1000;

    logic               CLK = 1'b0;
    logic               reset_n = 1'b0;
    logic               hall1 = 1'b1, hall2 = 1'b0, hall3 = 1'b1;
    logic               zero_pos = 1'b0, clear_error = 1'b0;
    logic signed [31:0] position;
    logic [2:0]         sector;
    logic               direction, step_strobe, hall_error, vel_valid;
    logic [7:0]         error_count;
    logic signed [15:0] velocity;

    hall_position_decoder #(
        .DEBOUNCE_CYCLES(DEB), .VEL_WINDOW(WIN), .ERR_CNT_W(8)
    ) dut (
        .CLK(CLK), .reset_n(reset_n),
        .hall1(hall1), .hall2(hall2), .hall3(hall3),
        .zero_pos(zero_pos), .clear_error(clear_error),
        .position(position), .sector(sector), .direction(direction),
        .step_strobe(step_strobe), .hall_error(hall_error),
        .error_count(error_count), .velocity(velocity), .vel_valid(vel_valid)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int n_strobe = 0;
    bit vel_seen = 1'b0;

    always @(negedge CLK) begin
        if (reset_n && step_strobe) n_strobe++;
        if (velocity != 16'sd0 || vel_valid) vel_seen = 1'b1;
    end

    // Reference model: sector index arithmetic on accepted codes.
    int         code2sec[8] = '{7, 5, 3, 4, 1, 0, 2, 7};
    logic [2:0] sec2code[6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    bit         m_init, m_dir, m_err;
    int         m_sector, m_pos, m_errcnt, m_strobes;
    logic [2:0] m_acc;

    task automatic m_reset();
        m_init = 1; m_dir = 1; m_err = 0;
        m_sector = 7; m_pos = 0; m_errcnt = 0; m_acc = 3'b000;
    endtask

    task automatic m_error();
        m_err = 1;
        if (m_errcnt < 255) m_errcnt++;
    endtask

    task automatic m_apply(input logic [2:0] code, input bit drop);
        int s, d;
        if (code == m_acc) return;
        m_acc = code;
        s = code2sec[code];
        if (m_init) begin
            if (s != 7) begin m_sector = s; m_init = 0; end
        end else if (s == 7) begin
            m_error(); m_sector = 7; m_init = 1;
        end else begin
            d = (s - m_sector + 6) % 6;
            if (d == 1 || d == 5) begin
                if (drop) m_pos = 0;
                else begin
                    m_pos += (d == 1) ? 1 : -1;
                    m_dir = (d == 1);
                    m_strobes++;
                end
            end else if (d != 0) begin
                m_error();
            end
            m_sector = s;
        end
        if (drop) m_pos = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_hall(input logic [2:0] c);
        {hall1, hall2, hall3} = c;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_pos"}, position, 32'(m_pos));
        chk({tag, "_sec"}, 32'(sector), 32'(m_sector));
        chk({tag, "_dir"}, 32'(direction), 32'(m_dir));
        chk({tag, "_err"}, 32'(hall_error), 32'(m_err));
        chk({tag, "_ecnt"}, 32'(error_count), 32'(m_errcnt));
        chk({tag, "_nstb"}, 32'(n_strobe), 32'(m_strobes));
    endtask

    task automatic drive(input string tag, input logic [2:0] c, input int hold);
        set_hall(c);
        cyc(hold);
        if (hold >= LAT) m_apply(c, 0);
        check_all(tag);
    endtask

    task automatic wait_vel();
        for (int i = 0; i < WIN + 100 && !vel_valid; i++) @(negedge CLK);
        chk("vel_wait", 32'(vel_valid), 32'd1);
    endtask

    initial begin
        logic [2:0] c;
        int mode;
        m_strobes = 0;
        m_reset();

        cyc(3);
        chk("rst_pos", position, 32'd0);
        chk("rst_sec", 32'(sector), 32'd7);
        chk("rst_dir", 32'(direction), 32'd1);
        chk("rst_stb", 32'(step_strobe), 32'd0);
        chk("rst_err", 32'(hall_error), 32'd0);
        chk("rst_ecnt", 32'(error_count), 32'd0);
        chk("rst_vel", 32'(velocity), 32'd0);
        chk("rst_vvld", 32'(vel_valid), 32'd0);

        reset_n = 1'b1;
        cyc(40);
        m_apply(3'b101, 0);
        check_all("init_load");

        for (int i = 1; i <= 6; i++) drive("fwd", sec2code[i % 6], 40);
        chk("fwd_pos6", position, 32'd6);
        chk("fwd_strobes6", 32'(n_strobe), 32'd6);

        zero_pos = 1'b1; cyc(1); zero_pos = 1'b0; m_pos = 0;
        check_all("zero");

        drive("rev", 3'b001, 40);
        drive("rev", 3'b011, 40);
        chk("rev_pos", position, 32'hFFFF_FFFE);
        chk("rev_dir", 32'(direction), 32'd0);

        drive("back", 3'b001, 40);
        drive("back", 3'b101, 40);
        drive("glitch", 3'b100, 5);
        drive("glitch_ret", 3'b101, 40);
        chk("glitch_pos", position, 32'd0);

        drive("skip", 3'b110, 40);
        chk("skip_err", 32'(hall_error), 32'd1);
        chk("skip_ecnt", 32'(error_count), 32'd1);
        chk("skip_sec", 32'(sector), 32'd2);

        drive("ill", 3'b000, 40);
        chk("ill_sec", 32'(sector), 32'd7);
        drive("reload", 3'b100, 40);
        chk("reload_sec", 32'(sector), 32'd1);
        chk("reload_pos", position, 32'd0);

        // Edge-to-strobe latency
        c = sec2code[(m_sector + 1) % 6];
        set_hall(c);
        cyc(LAT - 1);
        chk("lat_early", 32'(step_strobe), 32'd0);
        cyc(1);
        chk("lat_exact", 32'(step_strobe), 32'd1);
        m_apply(c, 0);
        cyc(1);
        chk("lat_pulse1", 32'(step_strobe), 32'd0);
        check_all("lat");

        drive("fwd2", sec2code[(m_sector + 1) % 6], 40);

        // zero_pos coincident with a step
        c = sec2code[(m_sector + 1) % 6];
        set_hall(c);
        cyc(LAT - 1);
        zero_pos = 1'b1;
        cyc(1);
        zero_pos = 1'b0;
        chk("zstep_stb", 32'(step_strobe), 32'd0);
        chk("zstep_pos", position, 32'd0);
        m_apply(c, 1);
        cyc(20);
        check_all("zstep");

        // clear_error coincident with a skip error
        c = sec2code[(m_sector + 2) % 6];
        set_hall(c);
        cyc(LAT - 1);
        clear_error = 1'b1;
        cyc(1);
        clear_error = 1'b0;
        m_errcnt = 0;
        m_apply(c, 0);
        chk("clrerr_ecnt", 32'(error_count), 32'd1);
        chk("clrerr_flag", 32'(hall_error), 32'd1);
        cyc(10);
        check_all("clrerr");

        clear_error = 1'b1; cyc(1); clear_error = 1'b0;
        m_err = 0; m_errcnt = 0;
        check_all("clear");

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(9, 0);
            if (m_sector == 7 || mode >= 8) c = 3'($urandom_range(7, 0));
            else if (mode < 4)              c = sec2code[(m_sector + 1) % 6];
            else if (mode < 7)              c = sec2code[(m_sector + 5) % 6];
            else                            c = sec2code[(m_sector + 2 + $urandom_range(2, 0)) % 6];
            drive("rnd", c, $urandom_range(45, 25));
        end

        drive("pre_vel", 3'b101, 40);
`ifdef HALL_VELOCITY_EN
        wait_vel();
        for (int i = 0; i < 10; i++) drive("vel_step", sec2code[(m_sector + 1) % 6], 40);
        cyc(WIN - 400 - LAT);
        c = sec2code[(m_sector + 1) % 6];
        set_hall(c);
        cyc(LAT);
        m_apply(c, 0);
        chk("vel_term_valid", 32'(vel_valid), 32'd1);
        chk("vel_ten", 32'(velocity), 32'd10);
        chk("vel_term_stb", 32'(step_strobe), 32'd1);
        cyc(1);
        chk("vel_pulse1", 32'(vel_valid), 32'd0);
        wait_vel();
        chk("vel_carry", 32'(velocity), 32'd1);
        check_all("vel_end");
`else
        cyc(WIN + 50);
        chk("vel_tied0", 32'(vel_seen), 32'd0);
`endif

        // Reset in the middle of a debounce interval
        c = sec2code[(m_sector + 3) % 6];
        set_hall(c);
        cyc(10);
        reset_n = 1'b0;
        cyc(2);
        m_reset();
        check_all("mid_rst");
        reset_n = 1'b1;
        cyc(40);
        m_apply(c, 0);
        check_all("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
